mem_stage_sized: RTL and testbench

//  Parametrised MEM-phase stage: sits between EX/MEM and MEM/WB in place of the fixed single-cycle stage.

---
 rtl/mem_stage_sized.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_sized.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sized.sv
// MEM-phase stage with word-organised data memory, sub-word access, sign/zero extension and
// programmable access latency; stalls the pipeline until each aligned access completes.
module mem_stage_sized #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data2,
  output logic        stall,
  output logic [31:0] read_data_out,
  output logic        rdata_valid,
  output logic        misalign
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_idx;
  logic [1:0]        lat_lane;
  logic [1:0]        lat_size;
  logic [31:0]       lat_data;
  logic              lat_store;
  logic              lat_load;
  logic              lat_uns;

  logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

  logic        access;
  logic        aligned;
  logic        accept;
  logic        finish;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        unused_addr;

  // Address bits above the word index are intentionally ignored so the index wraps.
  assign unused_addr = ^alu_result[31:ADDR_W+2];

  assign access = req_valid & (memread | memwrite);
  assign finish = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    aligned = 1'b1;
    case (size)
      2'b01:   aligned = ~alu_result[0];
      2'b10:   aligned = 1'b1;
      default: aligned = (alu_result[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    misalign    = 1'b0;
    rdata_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = BUSY;
          end else begin
            misalign  = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        // The request still held upstream is stale here and is never re-accepted.
        rdata_valid = lat_load;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      stall       = 1'b0;
      misalign    = 1'b0;
      rdata_valid = 1'b0;
      accept      = 1'b0;
      state_nxt   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      read_data_out <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish && lat_load) read_data_out <= rd_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx   <= alu_result[ADDR_W+1:2];
      lat_lane  <= alu_result[1:0];
      lat_size  <= size;
      lat_data  <= read_data2;
      lat_store <= memwrite;
      lat_load  <= memread & ~memwrite;
      lat_uns   <= load_unsigned;
    end
  end

  assign rd_word  = mem[lat_idx];
  assign rd_shift = rd_word >> {lat_lane, 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    case (lat_size)
      2'b10:   rd_ext = {{24{~lat_uns & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{~lat_uns & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // Sub-word stores replicate the data across the word; the byte enable picks the lane.
  always_comb begin
    wr_data = lat_data;
    wr_be   = 4'b1111;
    case (lat_size)
      2'b10: begin
        wr_data = {4{lat_data[7:0]}};
        wr_be   = 4'b0001 << lat_lane;
      end
      2'b01: begin
        wr_data = {2{lat_data[15:0]}};
        wr_be   = lat_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = lat_data;
        wr_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (finish && lat_store && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[lat_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sized.sv
// Bench for mem_stage_sized: LATENCY=2 and LATENCY=1 instances sharing stimulus, gated by sel;
// load results are checked against a scoreboard of expected values pushed at issue time.
module tb_mem_stage_sized;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] read_data2 = 32'h0;
  logic        sel = 1'b0;

  logic        stall0, stall1, rv0, rv1, mis0, mis1;
  logic [31:0] rdo0, rdo1;
  logic        st, rv, mis;
  logic [31:0] rdo;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  mem_stage_sized #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .memwrite(memwrite),
    .memread(memread), .size(size), .load_unsigned(load_unsigned), .alu_result(alu_result),
    .read_data2(read_data2), .stall(stall0), .read_data_out(rdo0), .rdata_valid(rv0),
    .misalign(mis0)
  );

  mem_stage_sized #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .memwrite(memwrite),
    .memread(memread), .size(size), .load_unsigned(load_unsigned), .alu_result(alu_result),
    .read_data2(read_data2), .stall(stall1), .read_data_out(rdo1), .rdata_valid(rv1),
    .misalign(mis1)
  );

  assign st  = sel ? stall1 : stall0;
  assign rv  = sel ? rv1    : rv0;
  assign mis = sel ? mis1   : mis0;
  assign rdo = sel ? rdo1   : rdo0;

  // Starts at posedge+1, holds the request while stalled and through the DONE cycle,
  // and returns at posedge+1 with the request dropped.
  task automatic access(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_stall,
                        input logic exp_rv, input logic exp_mis, input logic [31:0] exp_data,
                        input string name);
    int  n;
    bit  done;
    logic [31:0] e;
    req_valid = 1'b1; memwrite = wr; memread = rd; size = sz;
    load_unsigned = uns; alu_result = addr; read_data2 = wdata;
    if (exp_rv) sb.push_back(exp_data);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (st) begin
        n++;
        if (rv) begin
          checks++; errors++;
          $display("FAIL %s rdata_valid during stall: got 1 want 0", name);
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: stall never dropped", name);
    end
    checks++;
    if (n !== exp_stall) begin
      errors++; $display("FAIL %s stall cycles: got %0d want %0d", name, n, exp_stall);
    end
    checks++;
    if (mis !== exp_mis) begin
      errors++; $display("FAIL %s misalign: got %b want %b", name, mis, exp_mis);
    end
    checks++;
    if (rv !== exp_rv) begin
      errors++; $display("FAIL %s rdata_valid: got %b want %b", name, rv, exp_rv);
    end
    if (rv === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s unexpected load result: got %h want none", name, rdo);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rdo !== e) begin
          errors++; $display("FAIL %s data: got %h want %h", name, rdo, e);
        end
      end
    end else if (exp_rv && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    req_valid = 1'b0; memwrite = 1'b0; memread = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks += 4;
    if (st !== 1'b0)         begin errors++; $display("FAIL reset stall: got %b want 0", st); end
    if (rv !== 1'b0)         begin errors++; $display("FAIL reset rdata_valid: got %b want 0", rv); end
    if (mis !== 1'b0)        begin errors++; $display("FAIL reset misalign: got %b want 0", mis); end
    if (rdo !== 32'h0)       begin errors++; $display("FAIL reset read_data_out: got %h want 0", rdo); end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    access(1, 0, 2'b00, 0, 32'h10, 32'hDEADBEEF, 3, 0, 0, 32'h0, "sw_10");
    access(0, 1, 2'b00, 0, 32'h10, 32'h0, 3, 1, 0, 32'hDEADBEEF, "lw_10");
    access(0, 0, 2'b00, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, "no_access");
  endtask

  task automatic test_byte();
    access(1, 0, 2'b10, 0, 32'h21, 32'h1234567F, 3, 0, 0, 32'h0, "sb_21");
    access(1, 0, 2'b10, 0, 32'h22, 32'hABCDEF80, 3, 0, 0, 32'h0, "sb_22");
    access(0, 1, 2'b10, 0, 32'h22, 32'h0, 3, 1, 0, 32'hFFFFFF80, "lb_22");
    access(0, 1, 2'b10, 1, 32'h22, 32'h0, 3, 1, 0, 32'h00000080, "lbu_22");
    access(0, 1, 2'b00, 0, 32'h20, 32'h0, 3, 1, 0, 32'h00807F00, "lw_20");
  endtask

  task automatic test_half();
    access(1, 0, 2'b01, 0, 32'h32, 32'hABCD8001, 3, 0, 0, 32'h0, "sh_32");
    access(0, 1, 2'b01, 0, 32'h32, 32'h0, 3, 1, 0, 32'hFFFF8001, "lh_32");
    access(0, 1, 2'b01, 1, 32'h32, 32'h0, 3, 1, 0, 32'h00008001, "lhu_32");
    access(0, 1, 2'b01, 0, 32'h31, 32'h0, 0, 0, 1, 32'h0, "lh_31_misalign");
    access(1, 0, 2'b00, 0, 32'h32, 32'h55555555, 0, 0, 1, 32'h0, "sw_32_misalign");
    access(0, 1, 2'b00, 0, 32'h30, 32'h0, 3, 1, 0, 32'h80010000, "lw_30");
  endtask

  task automatic test_wrap_rdwr();
    access(1, 0, 2'b00, 0, 32'h1000, 32'h12345678, 3, 0, 0, 32'h0, "sw_1000");
    access(0, 1, 2'b00, 0, 32'h0, 32'h0, 3, 1, 0, 32'h12345678, "lw_0_wrap");
    access(1, 1, 2'b00, 0, 32'h8, 32'hCAFEF00D, 3, 0, 0, 32'h0, "rdwr_8");
    access(0, 1, 2'b00, 0, 32'h8, 32'h0, 3, 1, 0, 32'hCAFEF00D, "lw_8");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; memwrite = 1'b1; memread = 1'b0; size = 2'b00;
    alu_result = 32'h40; read_data2 = 32'hAAAA5555;
    @(negedge clk);
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL rst_mid accept stall: got %b want 1", st); end
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0; memwrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks += 3;
    if (st !== 1'b0)   begin errors++; $display("FAIL rst_mid stall: got %b want 0", st); end
    if (rv !== 1'b0)   begin errors++; $display("FAIL rst_mid rdata_valid: got %b want 0", rv); end
    if (rdo !== 32'h0) begin errors++; $display("FAIL rst_mid read_data_out: got %h want 0", rdo); end
    @(posedge clk); #1;
    access(0, 1, 2'b00, 0, 32'h40, 32'h0, 3, 1, 0, 32'h0, "lw_40_after_rst");
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    access(1, 0, 2'b00, 0, 32'h0, 32'h11111111, 2, 0, 0, 32'h0, "l1_sw_0");
    access(1, 0, 2'b00, 0, 32'h4, 32'h22222222, 2, 0, 0, 32'h0, "l1_sw_4");
    access(0, 1, 2'b00, 0, 32'h0, 32'h0, 2, 1, 0, 32'h11111111, "l1_lw_0");
    access(0, 1, 2'b00, 0, 32'h4, 32'h0, 2, 1, 0, 32'h22222222, "l1_lw_4");
    access(0, 1, 2'b10, 0, 32'h5, 32'h0, 2, 1, 0, 32'h00000022, "l1_lb_5");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap_rdwr();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
